// File: rtl/sram_bus_arbiter_pkg.sv
// rtl/sram_bus_arbiter_pkg.sv - shared types and constants for the SRAM bus arbiter
// Bus widths, enable levels, FSM state encoding and the latched request
// record used by the arbiter and its wait counter.
package sram_bus_arbiter_pkg;

  localparam int REG_BUS       = 32;
  localparam int INST_ADDR_BUS = 32;
  localparam int SEL_W         = 4;
  localparam int WORD_ADDR_W   = INST_ADDR_BUS - 2;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  localparam logic [SEL_W-1:0] SEL_ALL = 4'b1111;

  // Access sequencer states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_DONE_I = 3'd3,
    ST_DONE_D = 3'd4
  } state_t;

  // One SRAM transfer as presented on the ram_* pins
  typedef struct packed {
    logic                     ce;
    logic                     we;
    logic [INST_ADDR_BUS-1:0] addr;
    logic [SEL_W-1:0]         sel;
    logic [REG_BUS-1:0]       wdata;
  } req_t;

  localparam req_t REQ_NONE = '0;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - SRAM wait-state counter with last-cycle flag
// Counts 0..WAIT_CYCLES-1 while an access is busy and flags the final
// busy cycle; it sits at zero whenever no access is in progress.
module sram_wait_counter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_last
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  assign o_last = (r_cnt == LAST_CNT);

  // Restart on a new grant or outside busy; advance once per busy cycle
  always_ff @(posedge clk) begin
    if (rst || i_load || !i_count) begin
      r_cnt <= '0;
    end else if (!o_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// rtl/sram_bus_arbiter.sv - IF/MEM arbiter for one single-port wait-stated SRAM
// Data accesses win over fetches (the MEM instruction is older). Each grant
// runs BUSY for WAIT_CYCLES cycles and DONE for one. A one-entry hold buffer
// keeps the last fetched word so a fetch repeated under a pipeline freeze
// completes without another SRAM access.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_ce_i,
  input  logic [INST_ADDR_BUS-1:0] inst_addr_i,
  output logic [REG_BUS-1:0]       inst_data_o,
  input  logic                     data_ce_i,
  input  logic                     data_we_i,
  input  logic [REG_BUS-1:0]       data_addr_i,
  input  logic [SEL_W-1:0]         data_sel_i,
  input  logic [REG_BUS-1:0]       data_wdata_i,
  output logic [REG_BUS-1:0]       data_rdata_o,
  output logic                     stallreq_if_o,
  output logic                     stallreq_mem_o,
  output logic                     ram_ce_o,
  output logic                     ram_we_o,
  output logic [REG_BUS-1:0]       ram_addr_o,
  output logic [SEL_W-1:0]         ram_sel_o,
  output logic [REG_BUS-1:0]       ram_wdata_o,
  input  logic [REG_BUS-1:0]       ram_rdata_i
);

  state_t                 r_state;
  state_t                 w_next_state;
  req_t                   r_req;
  req_t                   w_grant_req;
  logic                   r_hold_valid;
  logic [WORD_ADDR_W-1:0] r_hold_addr;
  logic [REG_BUS-1:0]     r_hold_word;
  logic [REG_BUS-1:0]     r_rdata;
  logic                   w_hold_hit;
  logic                   w_in_busy;
  logic                   w_cnt_last;
  logic                   w_grant;
  logic                   w_inst_end;
  logic                   w_data_end;

  assign w_hold_hit = r_hold_valid & inst_ce_i &
                      (inst_addr_i[INST_ADDR_BUS-1:2] == r_hold_addr);
  assign w_in_busy  = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);
  assign w_grant    = (r_state == ST_IDLE) &&
                      ((w_next_state == ST_BUSY_I) || (w_next_state == ST_BUSY_D));
  assign w_inst_end = (r_state == ST_BUSY_I) && w_cnt_last;
  assign w_data_end = (r_state == ST_BUSY_D) && w_cnt_last;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_grant),
    .i_count(w_in_busy),
    .o_last (w_cnt_last)
  );

  // Request that would be granted this cycle: data first, else the fetch
  always_comb begin
    w_grant_req = REQ_NONE;
    if (data_ce_i) begin
      w_grant_req.ce    = CHIP_ENABLE;
      w_grant_req.we    = data_we_i;
      w_grant_req.addr  = data_addr_i;
      w_grant_req.sel   = data_sel_i;
      w_grant_req.wdata = data_wdata_i;
    end else begin
      w_grant_req.ce    = CHIP_ENABLE;
      w_grant_req.we    = WRITE_DISABLE;
      w_grant_req.addr  = inst_addr_i;
      w_grant_req.sel   = SEL_ALL;
      w_grant_req.wdata = '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: grant only from IDLE, busy runs to the counter's last cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (data_ce_i) begin
          w_next_state = ST_BUSY_D;
        end else if (inst_ce_i && !w_hold_hit) begin
          w_next_state = ST_BUSY_I;
        end
      end
      ST_BUSY_I: if (w_cnt_last) w_next_state = ST_DONE_I;
      ST_BUSY_D: if (w_cnt_last) w_next_state = ST_DONE_D;
      ST_DONE_I: w_next_state = ST_IDLE;
      ST_DONE_D: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Stall requests: released in the matching DONE cycle or on a hold hit
  always_comb begin
    stallreq_mem_o = data_ce_i & (r_state != ST_DONE_D);
    stallreq_if_o  = inst_ce_i & (r_state != ST_DONE_I) & ~w_hold_hit;
  end

  // Latched request doubles as the registered ram_* drive; zero outside busy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req <= REQ_NONE;
    end else if (w_grant) begin
      r_req <= w_grant_req;
    end else if (!(w_in_busy && !w_cnt_last)) begin
      r_req <= REQ_NONE;
    end
  end

  // Hold buffer: fill at fetch end, drop on a completed write to the same word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_word  <= '0;
    end else if (w_inst_end) begin
      r_hold_valid <= 1'b1;
      r_hold_addr  <= r_req.addr[INST_ADDR_BUS-1:2];
      r_hold_word  <= ram_rdata_i;
    end else if (w_data_end && (r_req.we == WRITE_ENABLE) &&
                 (r_req.addr[INST_ADDR_BUS-1:2] == r_hold_addr)) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Data read capture on the last busy cycle; writes leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_data_end && (r_req.we == WRITE_DISABLE)) begin
      r_rdata <= ram_rdata_i;
    end
  end

  assign ram_ce_o     = r_req.ce;
  assign ram_we_o     = r_req.we;
  assign ram_addr_o   = r_req.addr;
  assign ram_sel_o    = r_req.sel;
  assign ram_wdata_o  = r_req.wdata;
  assign inst_data_o  = r_hold_word;
  assign data_rdata_o = r_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb/tb_sram_bus_arbiter.sv - bench for sram_bus_arbiter at WAIT_CYCLES 1 and 3
module tb_sram_bus_arbiter;

  localparam int W_A = 1;
  localparam int W_B = 3;

  logic        clk;
  logic        rst;
  logic        inst_ce;
  logic [31:0] inst_addr;
  logic        data_ce;
  logic        data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_sel;
  logic [31:0] data_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] d_inst_data  [2];
  logic [31:0] d_data_rdata [2];
  logic        d_stall_if   [2];
  logic        d_stall_mem  [2];
  logic        d_ram_ce     [2];
  logic        d_ram_we     [2];
  logic [31:0] d_ram_addr   [2];
  logic [3:0]  d_ram_sel    [2];
  logic [31:0] d_ram_wdata  [2];

  int n_tests = 0;
  int n_fail  = 0;

  sram_bus_arbiter #(.WAIT_CYCLES(W_A)) u_w1 (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce), .inst_addr_i(inst_addr), .inst_data_o(d_inst_data[0]),
    .data_ce_i(data_ce), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_sel_i(data_sel), .data_wdata_i(data_wdata), .data_rdata_o(d_data_rdata[0]),
    .stallreq_if_o(d_stall_if[0]), .stallreq_mem_o(d_stall_mem[0]),
    .ram_ce_o(d_ram_ce[0]), .ram_we_o(d_ram_we[0]), .ram_addr_o(d_ram_addr[0]),
    .ram_sel_o(d_ram_sel[0]), .ram_wdata_o(d_ram_wdata[0]), .ram_rdata_i(ram_rdata)
  );

  sram_bus_arbiter #(.WAIT_CYCLES(W_B)) u_w3 (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce), .inst_addr_i(inst_addr), .inst_data_o(d_inst_data[1]),
    .data_ce_i(data_ce), .data_we_i(data_we), .data_addr_i(data_addr),
    .data_sel_i(data_sel), .data_wdata_i(data_wdata), .data_rdata_o(d_data_rdata[1]),
    .stallreq_if_o(d_stall_if[1]), .stallreq_mem_o(d_stall_mem[1]),
    .ram_ce_o(d_ram_ce[1]), .ram_we_o(d_ram_we[1]), .ram_addr_o(d_ram_addr[1]),
    .ram_sel_o(d_ram_sel[1]), .ram_wdata_o(d_ram_wdata[1]), .ram_rdata_i(ram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access is a grant followed by W busy cycles and one done cycle;
  // m_age counts 1..W+1 across the whole access, m_acc is 0 none, 1 fetch, 2 data.
  bit          m_init = 1'b0;
  int          m_acc   [2];
  int          m_age   [2];
  logic [31:0] m_addr  [2];
  logic        m_we    [2];
  logic [3:0]  m_sel   [2];
  logic [31:0] m_wdata [2];
  logic        m_hv    [2];
  logic [31:0] m_ha    [2];
  logic [31:0] m_hw    [2];
  logic [31:0] m_dr    [2];

  function automatic int wc(input int k);
    return (k == 0) ? W_A : W_B;
  endfunction

  function automatic bit mhit(input int k);
    logic [31:0] ha;
    ha = m_ha[k];
    return m_hv[k] && inst_ce && (inst_addr[31:2] == ha[31:2]);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1'b1;
      for (int k = 0; k < 2; k++) begin
        m_acc[k] <= 0;   m_age[k] <= 0;   m_addr[k] <= '0; m_we[k] <= 1'b0;
        m_sel[k] <= '0;  m_wdata[k] <= '0; m_hv[k] <= 1'b0; m_ha[k] <= '0;
        m_hw[k] <= '0;   m_dr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_acc[k] == 0) begin
          if (data_ce) begin
            m_acc[k] <= 2; m_age[k] <= 1; m_addr[k] <= data_addr; m_we[k] <= data_we;
            m_sel[k] <= data_sel; m_wdata[k] <= data_wdata;
          end else if (inst_ce && !mhit(k)) begin
            m_acc[k] <= 1; m_age[k] <= 1; m_addr[k] <= inst_addr; m_we[k] <= 1'b0;
            m_sel[k] <= 4'hF; m_wdata[k] <= '0;
          end
        end else if (m_age[k] <= wc(k)) begin
          if (m_age[k] == wc(k)) begin
            if (m_acc[k] == 1) begin
              m_hv[k] <= 1'b1; m_ha[k] <= m_addr[k]; m_hw[k] <= ram_rdata;
            end else if (m_we[k]) begin
              if (m_hv[k] && (m_ha[k] >> 2) == (m_addr[k] >> 2)) m_hv[k] <= 1'b0;
            end else begin
              m_dr[k] <= ram_rdata;
            end
          end
          m_age[k] <= m_age[k] + 1;
        end else begin
          m_acc[k] <= 0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        bit busy, done_i, done_d;
        string p;
        p      = $sformatf("w%0d", wc(k));
        busy   = (m_acc[k] != 0) && (m_age[k] <= wc(k));
        done_i = (m_acc[k] == 1) && (m_age[k] == wc(k) + 1);
        done_d = (m_acc[k] == 2) && (m_age[k] == wc(k) + 1);
        chk({p, " ram_ce"},    32'(d_ram_ce[k]),    32'(busy));
        chk({p, " ram_we"},    32'(d_ram_we[k]),    32'(busy && m_we[k]));
        chk({p, " ram_addr"},  d_ram_addr[k],       busy ? m_addr[k] : 32'h0);
        chk({p, " ram_sel"},   32'(d_ram_sel[k]),   busy ? 32'(m_sel[k]) : 32'h0);
        chk({p, " ram_wdata"}, d_ram_wdata[k],      busy ? m_wdata[k] : 32'h0);
        chk({p, " stall_mem"}, 32'(d_stall_mem[k]), 32'(data_ce && !done_d));
        chk({p, " stall_if"},  32'(d_stall_if[k]),  32'(inst_ce && !done_i && !mhit(k)));
        chk({p, " inst_data"}, d_inst_data[k],      m_hw[k]);
        chk({p, " data_rdata"}, d_data_rdata[k],    m_dr[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle(input int n);
    step();
    inst_ce = 1'b0; data_ce = 1'b0; data_we = 1'b0;
    repeat (n - 1) step();
  endtask

  initial begin
    int n_ce;
    int n_st;
    rst = 1'b1; inst_ce = 1'b0; inst_addr = '0; data_ce = 1'b0; data_we = 1'b0;
    data_addr = '0; data_sel = '0; data_wdata = '0; ram_rdata = '0;
    step(); step();
    rst = 1'b0;
    settle();
    chk("reset ram_ce", 32'(d_ram_ce[0]), 32'h0);
    chk("reset ram_addr", d_ram_addr[1], 32'h0);
    chk("reset inst_data", d_inst_data[0], 32'h0);
    chk("reset data_rdata", d_data_rdata[1], 32'h0);
    idle(2);

    // Single fetch, WAIT_CYCLES=1
    step(); inst_ce = 1'b1; inst_addr = 32'h10; ram_rdata = 32'h3C010101; settle();
    chk("t1 stall_if t", 32'(d_stall_if[0]), 32'h1);
    chk("t1 ram_ce t", 32'(d_ram_ce[0]), 32'h0);
    step(); settle();
    chk("t1 stall_if t+1", 32'(d_stall_if[0]), 32'h1);
    chk("t1 ram_ce t+1", 32'(d_ram_ce[0]), 32'h1);
    chk("t1 ram_addr", d_ram_addr[0], 32'h10);
    chk("t1 ram_sel", 32'(d_ram_sel[0]), 32'hF);
    step(); settle();
    chk("t1 stall_if t+2", 32'(d_stall_if[0]), 32'h0);
    chk("t1 ram_ce t+2", 32'(d_ram_ce[0]), 32'h0);
    chk("t1 inst_data", d_inst_data[0], 32'h3C010101);
    chk("t1 w3 still stalled", 32'(d_stall_if[1]), 32'h1);
    step(); settle();
    chk("t1 hit no stall", 32'(d_stall_if[0]), 32'h0);
    chk("t1 hit no ram_ce", 32'(d_ram_ce[0]), 32'h0);
    repeat (2) step();
    idle(4);

    // Simultaneous requests: data first, fetch after one IDLE
    step(); inst_ce = 1'b1; inst_addr = 32'h40; data_ce = 1'b1; data_we = 1'b0;
    data_addr = 32'h100; data_sel = 4'hF; data_wdata = '0; ram_rdata = 32'hAABBCCDD; settle();
    chk("t2 stall_mem", 32'(d_stall_mem[0]), 32'h1);
    step(); settle();
    chk("t2 ram_ce data", 32'(d_ram_ce[0]), 32'h1);
    chk("t2 ram_addr data", d_ram_addr[0], 32'h100);
    step(); settle();
    chk("t2 data_rdata", d_data_rdata[0], 32'hAABBCCDD);
    chk("t2 stall_mem done", 32'(d_stall_mem[0]), 32'h0);
    chk("t2 stall_if held", 32'(d_stall_if[0]), 32'h1);
    step(); data_ce = 1'b0; ram_rdata = 32'h11112222; settle();
    chk("t2 idle gap", 32'(d_ram_ce[0]), 32'h0);
    step(); settle();
    chk("t2 fetch ram_ce", 32'(d_ram_ce[0]), 32'h1);
    chk("t2 fetch ram_addr", d_ram_addr[0], 32'h40);
    step(); settle();
    chk("t2 inst_data", d_inst_data[0], 32'h11112222);
    idle(6);

    // Data request during BUSY_I waits; replayed fetch then hits
    step(); inst_ce = 1'b1; inst_addr = 32'h80; ram_rdata = 32'h55556666; settle();
    step(); data_ce = 1'b1; data_we = 1'b0; data_addr = 32'h200; data_sel = 4'hF; settle();
    chk("t3 fetch not preempted", d_ram_addr[0], 32'h80);
    step(); settle();
    chk("t3 inst_data", d_inst_data[0], 32'h55556666);
    chk("t3 mem stalled", 32'(d_stall_mem[0]), 32'h1);
    step(); settle();
    chk("t3 hit stall_if", 32'(d_stall_if[0]), 32'h0);
    step(); ram_rdata = 32'h77778888; settle();
    chk("t3 data ram_addr", d_ram_addr[0], 32'h200);
    step(); settle();
    chk("t3 data_rdata", d_data_rdata[0], 32'h77778888);
    step(); data_ce = 1'b0; settle();
    chk("t3 hit no ram_ce", 32'(d_ram_ce[0]), 32'h0);
    idle(8);

    // Write to the held word invalidates the hold buffer
    step(); inst_ce = 1'b1; inst_addr = 32'h20; ram_rdata = 32'h12345678; settle();
    step(); step(); settle();
    chk("t4 inst_data", d_inst_data[0], 32'h12345678);
    step(); inst_ce = 1'b0; data_ce = 1'b1; data_we = 1'b1; data_addr = 32'h23;
    data_sel = 4'b0001; data_wdata = 32'hEEEEEEEE; settle();
    step(); settle();
    chk("t4 ram_we", 32'(d_ram_we[0]), 32'h1);
    chk("t4 ram_sel", 32'(d_ram_sel[0]), 32'h1);
    chk("t4 ram_addr", d_ram_addr[0], 32'h23);
    step(); settle();
    chk("t4 write keeps rdata", d_data_rdata[0], 32'h77778888);
    chk("t4 write releases mem", 32'(d_stall_mem[0]), 32'h0);
    step(); data_ce = 1'b0; data_we = 1'b0; inst_ce = 1'b1; inst_addr = 32'h20;
    ram_rdata = 32'h9ABCDEF0; settle();
    chk("t4 invalidated stall", 32'(d_stall_if[0]), 32'h1);
    step(); settle();
    chk("t4 refetch ram_ce", 32'(d_ram_ce[0]), 32'h1);
    step(); settle();
    chk("t4 refetch data", d_inst_data[0], 32'h9ABCDEF0);
    idle(8);

    // Single data read, WAIT_CYCLES=3
    step(); data_ce = 1'b1; data_we = 1'b0; data_addr = 32'h300; data_sel = 4'hF;
    ram_rdata = 32'hCAFEF00D; settle();
    n_ce = 0; n_st = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin step(); settle(); end
      n_ce += int'(d_ram_ce[1]);
      n_st += int'(d_stall_mem[1]);
    end
    chk("t6 ram_ce cycles", 32'(n_ce), 32'd3);
    chk("t6 stall_mem cycles", 32'(n_st), 32'd4);
    chk("t6 data_rdata", d_data_rdata[1], 32'hCAFEF00D);
    idle(8);

    // Reset in the second BUSY_D cycle, WAIT_CYCLES=3
    step(); inst_ce = 1'b1; inst_addr = 32'h500; ram_rdata = 32'h50505050; settle();
    repeat (5) begin step(); settle(); end
    chk("t5 held word", d_inst_data[1], 32'h50505050);
    step(); data_ce = 1'b1; data_we = 1'b0; data_addr = 32'h400; ram_rdata = 32'h0BADBEEF; settle();
    chk("t5 hit stall_if", 32'(d_stall_if[1]), 32'h0);
    step(); settle();
    chk("t5 busy c1", d_ram_addr[1], 32'h400);
    step(); rst = 1'b1; settle();
    chk("t5 busy c2", 32'(d_ram_ce[1]), 32'h1);
    step(); rst = 1'b0; data_ce = 1'b0; settle();
    chk("t5 ram_ce after rst", 32'(d_ram_ce[1]), 32'h0);
    chk("t5 ram_addr after rst", d_ram_addr[1], 32'h0);
    chk("t5 data_rdata after rst", d_data_rdata[1], 32'h0);
    chk("t5 inst_data after rst", d_inst_data[1], 32'h0);
    chk("t5 hold invalid", 32'(d_stall_if[1]), 32'h1);
    step(); settle();
    chk("t5 refetch ram_addr", d_ram_addr[1], 32'h500);
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one single-port, wait-stated SRAM between the instruction-fetch port (IF stage) and the data port (MEM stage byte-lane requests: address, we, sel, wdata).
- Sequences each access through a small FSM.
- Raises pipeline stall requests toward the stall controller until the access completes.
- Keeps a one-entry instruction hold buffer, so a fetch completed while the pipeline was frozen is not re-issued.

Parameters:
WAIT_CYCLES, 1, SRAM access cycles per transfer (>=1); read data valid in the last busy cycle.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
inst_ce_i  in  1  IF fetch request (level, held while stalled)
inst_addr_i  in  32  fetch byte address (word aligned)
inst_data_o  out  32  fetched instruction
data_ce_i  in  1  MEM access request (level)
data_we_i  in  1  1 = write
data_addr_i  in  32  data address, low 2 bits already resolved into sel
data_sel_i  in  4  byte-lane enables, bit3 = bits[31:24]
data_wdata_i  in  32  write data (lane-replicated)
data_rdata_o  out  32  read data (full word; MEM stage extracts lanes)
stallreq_if_o  out  1  stall PC/IF-ID
stallreq_mem_o  out  1  stall through EX/MEM
ram_ce_o  out  1  SRAM chip enable
ram_we_o  out  1  SRAM write enable
ram_addr_o  out  32  SRAM address
ram_sel_o  out  4  SRAM byte enables
ram_wdata_o  out  32  SRAM write data
ram_rdata_i  in  32  SRAM read data

Behaviour:
- Reset (rst high at clk edge):
  - state = IDLE, wait counter = 0, hold buffer invalid.
  - All ram_* outputs 0; inst_data_o and data_rdata_o are 0.
  - Reset mid-access aborts the access; ram_ce_o is 0 from the next cycle.
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- Transitions out of IDLE:
  - data_ce_i high → BUSY_D. Data has priority: it is the older instruction.
  - Otherwise, inst_ce_i high and not hold-hit → BUSY_I.
  - Otherwise stay in IDLE.
  - On entry to BUSY the granted request (addr, we, sel, wdata) is latched.
  - Instruction grants use sel = 4'b1111 and we = 0.
- ram_* outputs:
  - Registered; driven from the latched request throughout BUSY_x.
  - 0 in every other state.
  - Addresses are passed to the SRAM unmodified.
- Wait counter: counts 0..WAIT_CYCLES-1 in BUSY_x.
  - On the last busy cycle, ram_rdata_i is captured (reads only) and the next state is DONE_x.
  - BUSY_x lasts exactly WAIT_CYCLES cycles.
- DONE_x lasts exactly one cycle, then IDLE. No new grant is made in a DONE cycle.
- Accesses are non-preemptive: a data request arriving during BUSY_I waits until IDLE.
- Latency: request first seen in IDLE at cycle t → DONE at t+1+WAIT_CYCLES.
- Stall requests (combinational):
  - stallreq_mem_o = data_ce_i & (state != DONE_D).
  - stallreq_if_o = inst_ce_i & (state != DONE_I) & !hold_hit.
- Read data outputs:
  - data_rdata_o = captured word, stable from DONE_D until the next data read capture.
  - inst_data_o = hold buffer word.
- Instruction hold buffer:
  - On the BUSY_I→DONE_I edge, it stores {addr, word} and sets valid.
  - hold_hit = valid & inst_ce_i & (inst_addr_i[31:2] == held addr[31:2]).
  - A hit completes the fetch with zero stall and no SRAM access.
- Hold buffer invalidation:
  - Any completed data write whose word address equals the held address clears valid, on the BUSY_D→DONE_D edge.
  - A new BUSY_I capture replaces the entry.
- Simultaneous inst and data requests in IDLE: data is served first. IF stays stalled via stallreq_if_o; the fetch is granted on the first IDLE with no data request.
- Write access: data_rdata_o is unchanged; DONE_D still releases stallreq_mem_o.

Decomposition:
- Shared defines header:
  - State encodings (3-bit).
  - Width macros RegBus, InstAddrBus, sel width 4.
  - ChipEnable/ChipDisable and WriteEnable/WriteDisable, reused from the existing defines.
- One natural sub-module: sram_wait_counter (load, count, last-cycle flag), parameterised by WAIT_CYCLES.

Test Plan:
1. WAIT_CYCLES=1, inst_ce_i=1, addr 0x00000010, ram_rdata_i=0x3C010101 in BUSY_I.
   → stallreq_if_o high for cycles t and t+1, low at t+2.
   → inst_data_o=0x3C010101; ram_ce_o high only at t+1.
2. inst and data read requests together in IDLE, data addr 0x100, RAM returns 0xAABBCCDD.
   → BUSY_D first; data_rdata_o=0xAABBCCDD at DONE_D.
   → Then BUSY_I begins after one IDLE; ram_addr_o shows 0x100 before the fetch address.
3. Data request rises during BUSY_I.
   → Fetch completes (no preemption), then the data access runs.
   → The held fetch address re-presented afterwards hits the hold buffer: stallreq_if_o=0, no ram_ce_o pulse.
4. Hold holds fetch addr 0x20; data write, sel 4'b0001, addr 0x23.
   → valid cleared.
   → The next fetch of 0x20 goes to SRAM (ram_ce_o pulses, stall 1+WAIT_CYCLES cycles).
5. rst asserted in the second cycle of BUSY_D (WAIT_CYCLES=3).
   → Next cycle: state IDLE, all ram_* = 0, data_rdata_o=0, hold invalid.
6. WAIT_CYCLES=3, single data read.
   → ram_ce_o high exactly 3 cycles; stallreq_mem_o high 4 cycles, low in DONE_D.
